// File: rtl/matrix_host_loader.sv
// Host-side loader/reader for the matrix multiplier.
// Streams input words into shared memory while the multiplier is held in reset,
// releases it, waits for result_ready (with a watchdog), then reads the result
// region back out over a valid/ready stream. All outputs are registered.
module matrix_host_loader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12,
  parameter int LOAD_BASE  = 0,
  parameter int TIMEOUT_W  = 24
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   load_len,
  input  logic [ADDR_WIDTH-1:0] result_base,
  input  logic [ADDR_WIDTH:0]   result_len,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] mem_data_in,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic                  mem_write_enable,
  input  logic [DATA_WIDTH-1:0] mem_data_out,
  input  logic                  result_ready,
  output logic                  mult_reset,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  timeout_err
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD    = 3'd1;
  localparam logic [2:0] S_RELEASE = 3'd2;
  localparam logic [2:0] S_WAIT    = 3'd3;
  localparam logic [2:0] S_RD_ADDR = 3'd4;
  localparam logic [2:0] S_RD_DATA = 3'd5;
  localparam logic [2:0] S_RD_HOLD = 3'd6;
  localparam logic [2:0] S_FINISH  = 3'd7;

  localparam logic [ADDR_WIDTH-1:0] LOAD_BASE_A = ADDR_WIDTH'(LOAD_BASE);
  // Last watchdog count before expiry: WAIT may last 2^TIMEOUT_W-1 cycles.
  localparam logic [TIMEOUT_W-1:0]  WD_LAST     = {TIMEOUT_W{1'b1}} - {{(TIMEOUT_W-1){1'b0}}, 1'b1};

  logic [2:0]            state_q,    state_d;
  logic [ADDR_WIDTH:0]   load_len_q, load_len_d;
  logic [ADDR_WIDTH-1:0] res_base_q, res_base_d;
  logic [ADDR_WIDTH:0]   res_len_q,  res_len_d;
  logic [ADDR_WIDTH:0]   cnt_q,      cnt_d;      // load index k, then read index j
  logic [ADDR_WIDTH:0]   cnt_inc;
  logic [TIMEOUT_W-1:0]  wd_q,       wd_d;
  logic                  in_ready_q, in_ready_d;
  logic                  we_q,       we_d;
  logic [ADDR_WIDTH-1:0] addr_q,     addr_d;
  logic [DATA_WIDTH-1:0] wdata_q,    wdata_d;
  logic                  mreset_q,   mreset_d;
  logic [DATA_WIDTH-1:0] odata_q,    odata_d;
  logic                  ovalid_q,   ovalid_d;
  logic                  busy_q,     busy_d;
  logic                  done_q,     done_d;
  logic                  tmo_q,      tmo_d;

  // Next-state and next-output computation for the whole job sequence.
  always_comb begin
    state_d    = state_q;
    load_len_d = load_len_q;
    res_base_d = res_base_q;
    res_len_d  = res_len_q;
    cnt_d      = cnt_q;
    wd_d       = wd_q;
    in_ready_d = in_ready_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    odata_d    = odata_q;
    ovalid_d   = ovalid_q;
    tmo_d      = tmo_q;
    cnt_inc    = cnt_q + {{ADDR_WIDTH{1'b0}}, 1'b1};

    case (state_q)
      S_IDLE: begin
        if (start) begin
          load_len_d = load_len;
          res_base_d = result_base;
          res_len_d  = result_len;
          tmo_d      = 1'b0;
          cnt_d      = {(ADDR_WIDTH+1){1'b0}};
          if (load_len == {(ADDR_WIDTH+1){1'b0}}) begin
            state_d    = S_RELEASE;
            in_ready_d = 1'b0;
          end else begin
            state_d    = S_LOAD;
            in_ready_d = 1'b1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        // Stay one extra cycle after the last beat so the final write is
        // still issued while the multiplier is held in reset.
        if (in_ready_q) begin
          if (in_valid) begin
            we_d    = 1'b1;
            addr_d  = LOAD_BASE_A + cnt_q[ADDR_WIDTH-1:0];
            wdata_d = in_data;
            cnt_d   = cnt_inc;
            if (cnt_inc == load_len_q) begin
              in_ready_d = 1'b0;
            end else begin
              in_ready_d = 1'b1;
            end
          end else begin
            in_ready_d = 1'b1;
          end
        end else begin
          state_d = S_RELEASE;
        end
      end
      S_RELEASE: begin
        wd_d    = {TIMEOUT_W{1'b0}};
        cnt_d   = {(ADDR_WIDTH+1){1'b0}};
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (result_ready) begin
          if (res_len_q == {(ADDR_WIDTH+1){1'b0}}) begin
            state_d = S_FINISH;
          end else begin
            state_d = S_RD_ADDR;
            addr_d  = res_base_q + cnt_q[ADDR_WIDTH-1:0];
          end
        end else if (wd_q == WD_LAST) begin
          tmo_d   = 1'b1;
          state_d = S_FINISH;
        end else begin
          wd_d = wd_q + {{(TIMEOUT_W-1){1'b0}}, 1'b1};
        end
      end
      S_RD_ADDR: begin
        state_d = S_RD_DATA;
      end
      S_RD_DATA: begin
        odata_d  = mem_data_out;
        ovalid_d = 1'b1;
        state_d  = S_RD_HOLD;
      end
      S_RD_HOLD: begin
        if (out_ready) begin
          ovalid_d = 1'b0;
          cnt_d    = cnt_inc;
          if (cnt_inc == res_len_q) begin
            state_d = S_FINISH;
          end else begin
            state_d = S_RD_ADDR;
            addr_d  = res_base_q + cnt_inc[ADDR_WIDTH-1:0];
          end
        end else begin
          state_d = S_RD_HOLD;
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d   = (state_d != S_IDLE);
    done_d   = (state_d == S_FINISH);
    mreset_d = (state_d == S_IDLE) || (state_d == S_LOAD) || (state_d == S_FINISH);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      load_len_q <= {(ADDR_WIDTH+1){1'b0}};
      res_base_q <= {ADDR_WIDTH{1'b0}};
      res_len_q  <= {(ADDR_WIDTH+1){1'b0}};
      cnt_q      <= {(ADDR_WIDTH+1){1'b0}};
      wd_q       <= {TIMEOUT_W{1'b0}};
      in_ready_q <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= {ADDR_WIDTH{1'b0}};
      wdata_q    <= {DATA_WIDTH{1'b0}};
      mreset_q   <= 1'b1;
      odata_q    <= {DATA_WIDTH{1'b0}};
      ovalid_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      tmo_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      load_len_q <= load_len_d;
      res_base_q <= res_base_d;
      res_len_q  <= res_len_d;
      cnt_q      <= cnt_d;
      wd_q       <= wd_d;
      in_ready_q <= in_ready_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      mreset_q   <= mreset_d;
      odata_q    <= odata_d;
      ovalid_q   <= ovalid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      tmo_q      <= tmo_d;
    end
  end

  assign in_ready         = in_ready_q;
  assign mem_write_enable = we_q;
  assign mem_address      = addr_q;
  assign mem_data_in      = wdata_q;
  assign mult_reset       = mreset_q;
  assign out_data         = odata_q;
  assign out_valid        = ovalid_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign timeout_err      = tmo_q;

endmodule

// File: tb/tb_matrix_host_loader.sv
// Self-checking bench for matrix_host_loader: table of jobs plus random jobs,
// checked against a word-level model of memory contents and expected streams.
module tb_matrix_host_loader;
  localparam int DW = 32;
  localparam int AW = 12;
  localparam int TW = 4;
  localparam int LB = 0;
  localparam int MEMN = 4096;

  logic          clk = 1'b0;
  logic          reset, start, in_valid, result_ready, out_ready;
  logic [AW:0]   load_len, result_len;
  logic [AW-1:0] result_base;
  logic [DW-1:0] in_data, mem_data_in, mem_data_out, out_data;
  logic [AW-1:0] mem_address;
  logic          in_ready, mem_write_enable, mult_reset, out_valid, busy, done, timeout_err;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  matrix_host_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LOAD_BASE(LB), .TIMEOUT_W(TW)) dut (
    .clk(clk), .reset(reset), .start(start), .load_len(load_len),
    .result_base(result_base), .result_len(result_len), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .mem_data_in(mem_data_in),
    .mem_address(mem_address), .mem_write_enable(mem_write_enable),
    .mem_data_out(mem_data_out), .result_ready(result_ready), .mult_reset(mult_reset),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done), .timeout_err(timeout_err));

  // Shared memory stand-in with 1-cycle read latency and a backdoor preload port.
  logic [DW-1:0] mem [0:MEMN-1];
  logic          bd_we;
  logic [AW-1:0] bd_addr;
  logic [DW-1:0] bd_data;
  always @(posedge clk) begin
    if (bd_we) mem[bd_addr] <= bd_data;
    else if (mem_write_enable) mem[mem_address] <= mem_data_in;
    mem_data_out <= mem[mem_address];
  end

  // Reference view of memory, updated only from the stimulus the bench issues.
  logic [DW-1:0] ref_mem [0:MEMN-1];

  typedef struct {
    int ll; int rb; int rl; int dly; int vmode; int rmode; bit seq;
  } vec_t;
  vec_t vt [9];

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_we"}, mem_write_enable, 0);
    chk({tag, "_addr"}, mem_address, 0);
    chk({tag, "_wdata"}, mem_data_in, 0);
    chk({tag, "_mult_reset"}, mult_reset, 1);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_data"}, out_data, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_timeout"}, timeout_err, 0);
  endtask

  // Runs one job: a garbage start is pulsed in the cycle after the real one.
  task automatic run_job(input vec_t v);
    logic [DW-1:0] words[$];
    logic [DW-1:0] exp_out[$];
    logic [DW-1:0] got_out[$];
    int idx = 0, wr_seen = 0, relcnt = 0, done_cnt = 0, mr_low = 0, after = 0, stall = 0;
    bit hold_p = 1'b0;
    bit exp_to;
    logic [DW-1:0] data_p;
    logic [AW-1:0] addr_p;
    exp_to = (v.dly < 0);
    for (int k = 0; k < v.ll; k++) begin
      words.push_back(v.seq ? DW'(k + 1) : DW'($urandom));
      ref_mem[(LB + k) % MEMN] = words[k];
    end
    if (!exp_to)
      for (int j = 0; j < v.rl; j++) exp_out.push_back(ref_mem[(v.rb + j) % MEMN]);
    @(negedge clk);
    start = 1'b1;
    load_len = (AW+1)'(v.ll);
    result_base = AW'(v.rb);
    result_len = (AW+1)'(v.rl);
    for (int cyc = 0; cyc < 3000 && after < 3; cyc++) begin
      @(negedge clk);
      start = (cyc == 0);
      load_len = 13'd7; result_base = 12'hFFF; result_len = 13'd9;
      if (mem_write_enable) begin
        if (wr_seen < v.ll) begin
          chk("wr_addr", mem_address, (LB + wr_seen) % MEMN);
          chk("wr_data", mem_data_in, words[wr_seen]);
          chk("wr_mult_reset", mult_reset, 1);
          if (wr_seen == v.ll - 1) chk("in_ready_after_last", in_ready, 0);
        end else begin
          chk("wr_extra", wr_seen, v.ll);
        end
        wr_seen++;
      end
      if (hold_p) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, data_p);
        chk("hold_addr", mem_address, addr_p);
      end
      if (done_cnt == 0) chk("busy_in_job", busy, 1);
      if (idx < v.ll) begin
        if (v.vmode == 0) in_valid = 1'b1;
        else if (v.vmode == 1) in_valid = (cyc % 2 == 0) ? 1'b1 : 1'b0;
        else in_valid = 1'($urandom_range(1, 0));
        in_data = words[idx];
        if (in_valid && in_ready) idx++;
      end else begin
        in_valid = 1'b0;
        in_data = 32'h0;
      end
      if (!mult_reset) begin
        relcnt++;
        mr_low++;
      end
      result_ready = (!mult_reset && !exp_to && relcnt > v.dly);
      if (v.rmode == 1) out_ready = 1'($urandom_range(1, 0));
      else if (v.rmode == 2 && out_valid && got_out.size() == 1 && stall < 20) begin
        out_ready = 1'b0;
        stall++;
      end else out_ready = 1'b1;
      if (out_valid && out_ready) got_out.push_back(out_data);
      hold_p = out_valid && !out_ready;
      data_p = out_data;
      addr_p = mem_address;
      if (done) begin
        done_cnt++;
        chk("done_mult_reset", mult_reset, 1);
        chk("done_busy", busy, 1);
        chk("done_timeout", timeout_err, exp_to);
      end
      if (done_cnt > 0) after++;
    end
    chk("wr_count", wr_seen, v.ll);
    chk("out_count", got_out.size(), exp_out.size());
    for (int j = 0; j < got_out.size() && j < exp_out.size(); j++)
      chk("out_word", got_out[j], exp_out[j]);
    chk("done_count", done_cnt, 1);
    chk("busy_end", busy, 0);
    chk("mult_reset_end", mult_reset, 1);
    chk("timeout_end", timeout_err, exp_to);
    if (exp_to) chk("wait_cycles", mr_low, 16);
    if (v.rmode == 2) chk("stall_len", stall, 20);
    in_valid = 1'b0; result_ready = 1'b0; out_ready = 1'b0; start = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    vec_t rv;
    int idx, wr_seen;
    vt[0] = '{4, 0, 4, 3, 0, 0, 1'b1};      // words 1..4, in_valid held
    vt[1] = '{6, 0, 6, 2, 1, 0, 1'b0};      // in_valid toggling
    vt[2] = '{0, 100, 3, 10, 0, 0, 1'b0};   // readback 0xA,0xB,0xC after 10 cycles
    vt[3] = '{3, 20, 4, 1, 0, 2, 1'b0};     // consumer stall 20 cycles
    vt[4] = '{2, 0, 2, -1, 0, 0, 1'b0};     // result never comes: watchdog
    vt[5] = '{0, 4094, 4, 0, 0, 1, 1'b0};   // read address wraps
    vt[6] = '{5, 0, 0, 4, 0, 0, 1'b0};      // result_len = 0
    vt[7] = '{0, 0, 0, 0, 0, 0, 1'b0};      // empty job
    vt[8] = '{20, 3, 12, 5, 2, 1, 1'b0};    // random gating both sides

    reset = 1'b1; start = 1'b0; in_valid = 1'b0; result_ready = 1'b0; out_ready = 1'b0;
    load_len = 13'd0; result_len = 13'd0; result_base = 12'd0; in_data = 32'h0;
    bd_we = 1'b0; bd_addr = 12'd0; bd_data = 32'h0;
    for (int i = 0; i < MEMN; i++) begin
      @(negedge clk);
      bd_we = 1'b1;
      bd_addr = AW'(i);
      if (i >= 100 && i <= 102) bd_data = DW'(i - 90);
      else bd_data = DW'($urandom);
      ref_mem[i] = bd_data;
    end
    @(negedge clk);
    bd_we = 1'b0;
    @(negedge clk);
    check_reset_vals("reset");
    reset = 1'b0;
    @(negedge clk);
    check_reset_vals("idle");

    for (int t = 0; t < 9; t++) run_job(vt[t]);

    // Reset in the middle of a load: two words already written stay in memory.
    @(negedge clk);
    start = 1'b1; load_len = 13'd4; result_base = 12'd0; result_len = 13'd2;
    idx = 0; wr_seen = 0;
    for (int cyc = 0; cyc < 50 && wr_seen < 2; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (mem_write_enable) wr_seen++;
      in_valid = 1'b1;
      in_data = 32'h11 * DW'(idx + 1);
      if (in_ready) idx++;
    end
    chk("midload_writes", wr_seen, 2);
    reset = 1'b1;
    ref_mem[0] = 32'h11;
    ref_mem[1] = 32'h22;
    @(negedge clk);
    in_valid = 1'b0;
    check_reset_vals("midload");
    reset = 1'b0;
    rv = '{0, 0, 2, 2, 0, 0, 1'b0};
    run_job(rv);

    for (int r = 0; r < 10; r++) begin
      rv.ll = $urandom_range(24, 1);
      rv.rb = $urandom_range(MEMN - 1, 0);
      rv.rl = $urandom_range(10, 1);
      rv.dly = $urandom_range(12, 0);
      rv.vmode = $urandom_range(2, 0);
      rv.rmode = $urandom_range(1, 0);
      rv.seq = 1'b0;
      run_job(rv);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
